// File: rtl/sprite_pixel_fetch_if.sv
// Pixel-scan, ROM and decoder-facing signals of the sprite pixel fetch stage.
// master = scan timing / ROM side, slave = sprite_pixel_fetch.
interface sprite_pixel_fetch_if #(
  parameter int CNT_W  = 10,
  parameter int ADDR_W = 10
);
  logic              pix_en;
  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic              frame_start;
  logic [CNT_W-1:0]  pos_x_in;
  logic [CNT_W-1:0]  pos_y_in;
  logic              flip_in;
  logic              is_b_in;
  logic              flash_trig;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_data;
  logic [3:0]        color_index;
  logic              is_b;
  logic              opaque;
  logic              flash_active;

  modport master (
    output pix_en, h_cnt, v_cnt, frame_start, pos_x_in, pos_y_in,
           flip_in, is_b_in, flash_trig, rom_data,
    input  rom_addr, color_index, is_b, opaque, flash_active
  );

  modport slave (
    input  pix_en, h_cnt, v_cnt, frame_start, pos_x_in, pos_y_in,
           flip_in, is_b_in, flash_trig, rom_data,
    output rom_addr, color_index, is_b, opaque, flash_active
  );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Sprite hit test, ROM address generation, palette capture and blue-flash FSM.
// Optional macro SPRITE_SCALE2X_EN: display the sprite at 2x scale.
module sprite_pixel_fetch #(
  parameter int SPR_W        = 32,
  parameter int SPR_H        = 32,
  parameter int ADDR_W       = 10,
  parameter int CNT_W        = 10,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_pixel_fetch_if.slave  bus
);
  localparam int XW = $clog2(SPR_W);
  localparam int EW = CNT_W + 1;
  localparam int CW = $clog2(FLASH_FRAMES + 1);
`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif
  localparam logic [EW-1:0] BOX_W = EW'(SPR_W << SC);
  localparam logic [EW-1:0] BOX_H = EW'(SPR_H << SC);

  typedef enum logic [0:0] {F_IDLE = 1'b0, F_FLASH = 1'b1} flash_e;

  logic [CNT_W-1:0]  sx_q, sy_q;
  logic              flip_q, shadow_b_q, shadow_valid_q;
  flash_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              phase_q, flash_active_q;
  logic [ADDR_W-1:0] addr_q;
  logic              hit0_q, hit1_q;
  logic [3:0]        data1_q, color_q;
  logic              is_b_q, opaque_q;

  logic [EW-1:0]     h_s, v_s, sx_s, sy_s, col_s, row_s;
  logic [XW-1:0]     src_col_s;
  logic              hit_s;
  logic [ADDR_W-1:0] addr_d;

  // Stage 0: bounding-box test and ROM address, all in CNT_W+1 bits to avoid edge wrap
  always_comb begin
    h_s       = {1'b0, bus.h_cnt};
    v_s       = {1'b0, bus.v_cnt};
    sx_s      = {1'b0, sx_q};
    sy_s      = {1'b0, sy_q};
    col_s     = h_s - sx_s;
    row_s     = v_s - sy_s;
    hit_s     = shadow_valid_q & (h_s >= sx_s) & (h_s < sx_s + BOX_W)
                               & (v_s >= sy_s) & (v_s < sy_s + BOX_H);
    src_col_s = XW'(col_s >> SC);
    // SPR_W is a power of two, so SPR_W-1-col is the bitwise complement
    src_col_s = flip_q ? ~src_col_s : src_col_s;
    addr_d    = (ADDR_W'(row_s >> SC) << XW) | ADDR_W'(src_col_s);
  end

  // Shadow copy of the sprite attributes, latched once per frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sx_q           <= '0;
      sy_q           <= '0;
      flip_q         <= 1'b0;
      shadow_b_q     <= 1'b0;
      shadow_valid_q <= 1'b0;
    end else if (bus.frame_start) begin
      sx_q           <= bus.pos_x_in;
      sy_q           <= bus.pos_y_in;
      flip_q         <= bus.flip_in;
      shadow_b_q     <= bus.is_b_in;
      shadow_valid_q <= 1'b1;
    end
  end

  // Blue-flash FSM; a trigger always wins over a coincident frame_start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= F_IDLE;
      cnt_q          <= '0;
      phase_q        <= 1'b0;
      flash_active_q <= 1'b0;
    end else if (bus.flash_trig) begin
      state_q        <= F_FLASH;
      cnt_q          <= CW'(FLASH_FRAMES);
      phase_q        <= (state_q == F_IDLE) | bus.frame_start | phase_q;
      flash_active_q <= 1'b1;
    end else if (bus.frame_start) begin
      case (state_q)
        F_FLASH: begin
          if (cnt_q == CW'(1)) begin
            state_q        <= F_IDLE;
            cnt_q          <= '0;
            phase_q        <= 1'b0;
            flash_active_q <= 1'b0;
          end else begin
            cnt_q          <= cnt_q - CW'(1);
            phase_q        <= ~phase_q;
            flash_active_q <= 1'b1;
          end
        end
        default: begin
          state_q        <= F_IDLE;
          cnt_q          <= '0;
          phase_q        <= 1'b0;
          flash_active_q <= 1'b0;
        end
      endcase
    end
  end

  // Three-tick pixel pipeline; ROM data is captured at stage 1 because pix_en
  // ticks are spaced at least two clocks apart and the ROM answers in one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      hit0_q   <= 1'b0;
      hit1_q   <= 1'b0;
      data1_q  <= 4'h0;
      color_q  <= 4'h0;
      is_b_q   <= 1'b0;
      opaque_q <= 1'b0;
    end else if (bus.pix_en) begin
      hit0_q   <= hit_s;
      addr_q   <= hit_s ? addr_d : addr_q;
      hit1_q   <= hit0_q;
      data1_q  <= bus.rom_data;
      color_q  <= hit1_q ? data1_q : 4'h0;
      opaque_q <= hit1_q & (data1_q != 4'h0);
      is_b_q   <= hit1_q & (shadow_b_q | phase_q);
    end
  end

  assign bus.rom_addr     = addr_q;
  assign bus.color_index  = color_q;
  assign bus.is_b         = is_b_q;
  assign bus.opaque       = opaque_q;
  assign bus.flash_active = flash_active_q;
endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Scoreboard bench for sprite_pixel_fetch: a frame-level reference model predicts
// each pixel's output; a monitor compares on every pix_en tick.
module tb_sprite_pixel_fetch;
  localparam int SPR_W = 32, SPR_H = 32, ADDR_W = 10, CNT_W = 10, FLASH_FRAMES = 8;
`ifdef SPRITE_SCALE2X_EN
  localparam int SCALE = 2;
`else
  localparam int SCALE = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_pixel_fetch_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  sprite_pixel_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .FLASH_FRAMES(FLASH_FRAMES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [3:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) bus.rom_data <= mem[bus.rom_addr];

  typedef struct {
    logic [3:0]        color;
    logic              isb;
    logic              opq;
    logic              fa;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t sb_q[$];
  exp_t me;
  int   n_chk = 0;
  int   n_pass = 0;

  // reference model state
  int m_sx, m_sy, m_rem, m_addr;
  bit m_flip, m_isb, m_sv, m_phase;
  bit hist_hit[$];
  int hist_col[$];

  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_sv = 0; m_rem = 0; m_phase = 0; m_addr = 0;
    hist_hit = '{1'b0, 1'b0};
    hist_col = '{0, 0};
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_color"}, bus.color_index, 0);
    check({tag, "_is_b"}, bus.is_b, 0);
    check({tag, "_opaque"}, bus.opaque, 0);
    check({tag, "_flash"}, bus.flash_active, 0);
    check({tag, "_addr"}, bus.rom_addr, 0);
  endtask

  // one pix_en tick followed by one idle clock
  task automatic issue(int h, int v);
    bit hit, old_hit;
    int col, row, ecol, addr;
    exp_t e;
    hit = m_sv && h >= m_sx && h < m_sx + SPR_W*SCALE && v >= m_sy && v < m_sy + SPR_H*SCALE;
    col = (h - m_sx) / SCALE;
    row = (v - m_sy) / SCALE;
    ecol = m_flip ? SPR_W - 1 - col : col;
    addr = hit ? (row*SPR_W + ecol) % (1 << ADDR_W) : 0;
    if (hit) m_addr = addr;
    hist_hit.push_back(hit);
    hist_col.push_back(hit ? int'(mem[addr]) : 0);
    old_hit = hist_hit.pop_front();
    e.color = 4'(hist_col.pop_front());
    e.opq   = old_hit && (e.color != 4'h0);
    e.isb   = old_hit && (m_isb || m_phase);
    e.fa    = (m_rem > 0);
    e.addr  = ADDR_W'(m_addr);
    sb_q.push_back(e);
    bus.h_cnt    = CNT_W'(h);
    bus.v_cnt    = CNT_W'(v);
    bus.pos_x_in = CNT_W'($urandom);
    bus.pos_y_in = CNT_W'($urandom);
    bus.flip_in  = 1'($urandom);
    bus.is_b_in  = 1'($urandom);
    bus.pix_en   = 1'b1;
    @(negedge clk);
    bus.pix_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic new_frame(int x, int y, bit f, bit b, bit trig);
    bus.pos_x_in = CNT_W'(x);
    bus.pos_y_in = CNT_W'(y);
    bus.flip_in  = f;
    bus.is_b_in  = b;
    bus.frame_start = 1'b1;
    bus.flash_trig  = trig;
    m_sx = x; m_sy = y; m_flip = f; m_isb = b; m_sv = 1;
    if (trig) begin
      m_rem = FLASH_FRAMES; m_phase = 1;
    end else if (m_rem > 0) begin
      m_rem--;
      m_phase = (m_rem == 0) ? 1'b0 : !m_phase;
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.flash_trig  = 1'b0;
  endtask

  task automatic trig_only();
    bus.flash_trig = 1'b1;
    if (m_rem == 0) m_phase = 1;
    m_rem = FLASH_FRAMES;
    @(negedge clk);
    bus.flash_trig = 1'b0;
  endtask

  task automatic flush();
    issue(0, 0);
    issue(0, 0);
  endtask

  // monitor: every pix_en tick retires one expectation
  initial begin
    forever begin
      @(posedge clk);
      if (bus.pix_en === 1'b1) begin
        #1;
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: got output tick, want queued expectation (t=%0t)", $time);
        end else begin
          me = sb_q.pop_front();
          check("color_index", bus.color_index, me.color);
          check("is_b", bus.is_b, me.isb);
          check("opaque", bus.opaque, me.opq);
          check("flash_active", bus.flash_active, me.fa);
          check("rom_addr", bus.rom_addr, me.addr);
        end
      end
    end
  end

  initial begin
    int x, y;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 4'(i);
    bus.pix_en = 1'b0; bus.h_cnt = '0; bus.v_cnt = '0; bus.frame_start = 1'b0;
    bus.pos_x_in = '0; bus.pos_y_in = '0; bus.flip_in = 1'b0; bus.is_b_in = 1'b0;
    bus.flash_trig = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic mapping and box edges
    new_frame(100, 50, 0, 0, 0);
    issue(100, 50); issue(105, 51); issue(132, 50); issue(99, 50); issue(131, 81); issue(100, 82);
    flush();
    new_frame(100, 50, 1, 0, 0);
    issue(100, 50); issue(131, 50); issue(117, 66);
    flush();

    // bottom-right corner: no wrap into low columns
    new_frame(620, 470, 0, 1, 0);
    foreach (hist_hit[k]) ; // keep queue shape unchanged
    for (int v = 469; v <= 480; v += 1) begin
      if (v == 469 || v == 470 || v == 479 || v == 480) begin
        for (int h = 0; h < 12; h++) issue(h, v);
        for (int h = 615; h < 640; h++) issue(h, v);
      end
    end
    issue(620, 0); issue(5, 5);
    flush();

    // flash: trigger then ten frames, one in-sprite pixel per frame
    new_frame(200, 100, 0, 0, 0);
    trig_only();
    for (int f = 0; f < 10; f++) begin
      issue(210, 110); flush();
      new_frame(200, 100, 0, 0, 0);
    end
    // flash re-triggered mid-flash at frame 4
    trig_only();
    for (int f = 0; f < 14; f++) begin
      if (f == 4) trig_only();
      issue(215, 112); flush();
      new_frame(200, 100, 0, 0, 0);
    end
    // trigger coinciding with frame_start
    new_frame(200, 100, 0, 0, 1);
    issue(215, 112); flush();

    // reset mid-line, then suppressed until the next frame_start
    new_frame(100, 50, 0, 1, 0);
    issue(101, 52); issue(102, 52); issue(103, 52);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(101, 52); issue(102, 52); issue(103, 52); issue(110, 60);
    new_frame(100, 50, 0, 0, 0);
    issue(101, 52); issue(103, 52);
    flush();

    // randomized frames
    for (int f = 0; f < 40; f++) begin
      x = (f % 5 == 0) ? $urandom_range(600, 639) : $urandom_range(0, 639);
      y = (f % 7 == 0) ? $urandom_range(450, 479) : $urandom_range(0, 479);
      new_frame(x, y, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 6) == 0) trig_only();
      for (int p = 0; p < 30; p++)
        issue((x - 4 + $urandom_range(0, 2*SPR_W*SCALE + 8)) % 1024,
              (y - 4 + $urandom_range(0, 2*SPR_H*SCALE + 8)) % 1024);
    end
    flush();

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
